// File: rtl/sync_filter.sv
// Multi-channel input conditioner: per-channel synchronizer followed by a
// consecutive-mismatch glitch filter. Define SYNC_FILTER_EDGE_EN for rise/fall pulses.
module sync_filter #(
    parameter int                  Channels     = 4,
    parameter int                  Stages       = 2,
    parameter int                  FilterCycles = 4,
    parameter logic [Channels-1:0] InitValue    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Channels-1:0] in,
    output logic [Channels-1:0] out,
    output logic [Channels-1:0] rise,
    output logic [Channels-1:0] fall,
    output logic [Channels-1:0] busy
);

    localparam int CntW = $clog2(FilterCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

    // Synchronized view of the inputs feeding the filter.
    logic [Channels-1:0] s;

    generate
        if (Stages > 0) begin : g_sync
            logic [Channels-1:0] sync_q [Stages];
            logic [Channels-1:0] sync_d [Stages];

            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = in;
                for (int k = 1; k < Stages; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < Stages; k++) begin
                        sync_q[k] <= InitValue;
                    end
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[Stages-1];
        end else begin : g_no_sync
            assign s = in;
        end
    endgenerate

    logic [CntW-1:0]     cnt_q [Channels];
    logic [CntW-1:0]     cnt_d [Channels];
    logic [Channels-1:0] out_q;
    logic [Channels-1:0] out_d;
    logic [Channels-1:0] commit;

    // Counter restarts whenever the synchronized level agrees with the output,
    // so a pending change needs an unbroken run of mismatches.
    always_comb begin
        out_d  = out_q;
        commit = '0;
        for (int i = 0; i < Channels; i++) begin
            cnt_d[i] = '0;
            if (s[i] != out_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    out_d[i]  = s[i];
                    commit[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= InitValue;
            for (int i = 0; i < Channels; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < Channels; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    assign out = out_q;

`ifdef SYNC_FILTER_EDGE_EN
    logic [Channels-1:0] rise_q;
    logic [Channels-1:0] rise_d;
    logic [Channels-1:0] fall_q;
    logic [Channels-1:0] fall_d;

    // A commit always flips the output, so the new level gives the direction.
    always_comb begin
        rise_d = commit & s;
        fall_d = commit & ~s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    logic [Channels-1:0] commit_unused;
    assign commit_unused = commit;
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed + random bench for sync_filter (Channels=4, Stages=2, FilterCycles=4,
// InitValue=4'b0101) with a cycle-level reference model and expected queue.
module tb_sync_filter;

  localparam int         FC   = 4;
  localparam logic [3:0] INIT = 4'b0101;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in;
  logic [3:0] out, rise, fall, busy;

  sync_filter #(
    .Channels    (4),
    .Stages      (2),
    .FilterCycles(FC),
    .InitValue   (INIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q[$];

  // Reference model state: two synchronizer stages, output, run counters, pulses.
  logic [3:0] m_sync0, m_sync1, m_out, m_rise, m_fall;
  int         m_cnt[4];

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sync0 = INIT;
    m_sync1 = INIT;
    m_out   = INIT;
    m_rise  = '0;
    m_fall  = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input logic [3:0] v);
    logic [3:0] s;
    logic [3:0] nxt;
    s   = m_sync1;
    nxt = m_out;
    for (int i = 0; i < 4; i++) begin
      if (s[i] === m_out[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] == FC - 1) begin
        nxt[i]   = s[i];
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
`ifdef SYNC_FILTER_EDGE_EN
    m_rise = nxt & ~m_out;
    m_fall = ~nxt & m_out;
`else
    m_rise = '0;
    m_fall = '0;
`endif
    m_out   = nxt;
    m_sync1 = m_sync0;
    m_sync0 = v;
  endtask

  function automatic logic [3:0] model_busy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic compare_head();
    logic [15:0] e;
    e = exp_q.pop_front();
    check("out", out, e[15:12]);
    check("rise", rise, e[11:8]);
    check("fall", fall, e[7:4]);
    check("busy", busy, e[3:0]);
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare just after.
  task automatic cycle(input logic [3:0] v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    model_edge(v);
    exp_q.push_back({m_out, m_rise, m_fall, model_busy()});
    #1;
    compare_head();
  endtask

  // Edges from the first capture until out[b] reaches lvl (bounded).
  task automatic edges_until(input logic [3:0] v, input int b, input logic lvl, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(v);
      n++;
      if (out[b] === lvl) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_hi;
    int commits;
    logic prev;
    logic [3:0] v;

    // Reset state, checked during and after reset
    in    = INIT;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out", out, INIT);
    check("rst_rise", rise, 4'b0000);
    check("rst_fall", fall, 4'b0000);
    check("rst_busy", busy, 4'b0000);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) cycle(INIT);

    // Latency: fall then rise on channel 0, each 6 edges
    edges_until(4'b0100, 0, 1'b0, n);
    check_int("lat_fall0", n, 6);
    check("fall_pulse", fall, 4'b0000 | (rise === 4'b0000 && fall === 4'b0000 ? 4'b0000 : 4'b0001));
    for (int k = 0; k < 3; k++) cycle(4'b0100);
    edges_until(4'b0101, 0, 1'b1, n);
    check_int("lat_rise0", n, 6);
    check("lat_out", out, 4'b0101);
    for (int k = 0; k < 3; k++) cycle(4'b0101);

    // Glitch rejection on channel 1
    busy_hi = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0111);
      busy_hi += int'(busy[1]);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(4'b0101);
      busy_hi += int'(busy[1]);
    end
    check_int("glitch_busy1", busy_hi, 3);
    check("glitch_out", out, 4'b0101);

    // Simultaneous toggle of all channels
    edges_until(4'b1010, 3, 1'b1, n);
    check_int("simul_lat", n, 6);
    check("simul_out", out, 4'b1010);
    for (int k = 0; k < 3; k++) cycle(4'b1010);

    // Counter restart on channel 2: 2 mismatch, 1 match, then held
    commits = 0;
    prev    = out[2];
    for (int k = 0; k < 11; k++) begin
      if (k < 2 || k > 2) v = 4'b1110;
      else v = 4'b1010;
      cycle(v);
      if (out[2] !== prev) commits++;
      prev = out[2];
    end
    check_int("restart_commits", commits, 1);
    check("restart_out", out, 4'b1110);

    // Random hold lengths
    for (int r = 0; r < 25; r++) begin
      v = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 6)) cycle(v);
    end

    // Settle to InitValue, then reset while channel 3 has cnt=2
    for (int k = 0; k < 10; k++) cycle(INIT);
    for (int k = 0; k < 4; k++) cycle(4'b1101);
    check("mid_busy_pre", busy, 4'b1000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_out", out, INIT);
    check("mid_rst_busy", busy, 4'b0000);
    @(posedge clk);
    #1;
    check("mid_rst_out2", out, INIT);
    check("mid_rst_edges", rise | fall, 4'b0000);
    reset = 1'b0;
    edges_until(4'b1101, 3, 1'b1, n);
    check_int("mid_rst_lat", n, 6);
    for (int k = 0; k < 3; k++) cycle(4'b1101);

    check_int("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
